iencoder_loader: RTL and testbench

- Inverse of the instruction decoder. Accepts decoded instruction fields in the core's internal 7-bit opcode format and re-encodes them into 32-bit ARM words.
- Buffers encoded words in a small FIFO and writes them sequentially into instruction memory from a programmable base address.
- Used by the test harness and boot path to load programs into instruction RAM.

---
 rtl/iencoder_loader_if.sv | 48 ++++
 rtl/iencoder_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_iencoder_loader.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iencoder_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : iencoder_loader_if
// Purpose  : Field-bundle, session-control and memory-write signals of the
//            instruction encoder/loader, with master/slave modports.
// Revision : 1.0
// ============================================================================
interface iencoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              finish;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        cond;
    logic [6:0]        opcode;
    logic              en_status;
    logic [3:0]        rn;
    logic [3:0]        rd;
    logic [3:0]        rs;
    logic [3:0]        rm;
    logic [1:0]        shift_op;
    logic [4:0]        imm5;
    logic [11:0]       imm12;
    logic [23:0]       imm24;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, base_addr, finish, in_valid, cond, opcode, en_status,
               rn, rd, rs, rm, shift_op, imm5, imm12, imm24, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err
    );

    modport slave (
        input  start, base_addr, finish, in_valid, cond, opcode, en_status,
               rn, rd, rs, rm, shift_op, imm5, imm12, imm24, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/iencoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : iencoder_loader
// Purpose  : Re-encodes internal 7-bit-opcode field bundles into 32-bit ARM
//            words, buffers them and writes them to instruction memory.
//            Optional macro ILLEGAL_TRAP_EN: illegal opcodes become HALT words.
// Revision : 1.0
// ============================================================================
module iencoder_loader #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    iencoder_loader_if.slave bus
);
    localparam int              c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] c_COUNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_sess_start;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_err;
    logic [31:0]       r_fifo [FIFO_DEPTH];
    logic [c_PTR_W:0]  r_wr_ptr;
    logic [c_PTR_W:0]  r_rd_ptr;

    logic              w_empty;
    logic              w_full;
    logic              w_active;
    logic              w_mem_we;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_push_data;

    logic [3:0]        w_grp;
    logic [2:0]        w_sub;
    logic [3:0]        w_op4;
    logic              w_op4_ok;
    logic              w_s_bit;
    logic              w_legal;
    logic [27:0]       w_body;
    logic [11:0]       w_ls_off;

    // ------------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------------
    assign w_grp    = bus.opcode[6:3];
    assign w_sub    = bus.opcode[2:0];
    assign w_s_bit  = bus.en_status | (w_sub == 3'b010);
    assign w_ls_off = bus.opcode[3] ? {bus.imm5, bus.shift_op, 1'b0, bus.rm} : bus.imm12;

    always_comb begin
        w_op4    = 4'b0000;
        w_op4_ok = 1'b1;
        case (w_sub)
            3'b000:  w_op4 = 4'b0100;
            3'b001:  w_op4 = 4'b0010;
            3'b010:  w_op4 = 4'b1010;
            3'b011:  w_op4 = 4'b0000;
            3'b100:  w_op4 = 4'b1100;
            3'b101:  w_op4 = 4'b0001;
            default: w_op4_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_legal = 1'b0;
        w_body  = 28'h0;
        case (w_grp)
            4'b0000: begin
                if (w_sub == 3'b000) begin
                    w_legal = 1'b1;
                    w_body  = {3'b001, 4'b1101, bus.en_status, 4'h0, bus.rd, bus.imm12};
                end else if (w_sub == 3'b001) begin
                    w_legal = 1'b1;
                    w_body  = {7'b0001000, 21'h0};
                end
            end
            4'b0001: begin
                w_legal = w_op4_ok;
                w_body  = {3'b001, w_op4, w_s_bit, bus.rn, bus.rd, bus.imm12};
            end
            4'b0010: begin
                w_legal = (w_sub == 3'b000);
                w_body  = {3'b000, 4'b1101, bus.en_status, 4'h0, bus.rd,
                           bus.imm5, bus.shift_op, 1'b0, bus.rm};
            end
            4'b0011: begin
                w_legal = w_op4_ok;
                w_body  = {3'b000, w_op4, w_s_bit, bus.rn, bus.rd,
                           bus.imm5, bus.shift_op, 1'b0, bus.rm};
            end
            4'b0110: begin
                w_legal = (w_sub == 3'b000);
                w_body  = {3'b000, 4'b1101, bus.en_status, 4'h0, bus.rd,
                           bus.rs, 1'b0, bus.shift_op, 1'b1, bus.rm};
            end
            4'b0111: begin
                w_legal = w_op4_ok;
                w_body  = {3'b000, w_op4, w_s_bit, bus.rn, bus.rd,
                           bus.rs, 1'b0, bus.shift_op, 1'b1, bus.rm};
            end
            4'b1000: begin
                w_legal = 1'b1;
                case (w_sub)
                    3'b000:  w_body = {4'b1010, bus.imm24};
                    3'b100:  w_body = {4'b1011, bus.imm24};
                    3'b001:  w_body = {24'h12FFF1, bus.rm};
                    3'b101:  w_body = {24'h12FFF3, bus.rm};
                    // remaining PUW codes are literal-pool loads off the PC
                    default: w_body = {3'b010, w_sub[2], w_sub[1], 1'b0, w_sub[0], 1'b1,
                                       4'hF, bus.rd, bus.imm12};
                endcase
            end
            4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
                w_legal = 1'b1;
                w_body  = {2'b01, bus.opcode[3], w_sub[2], w_sub[1], 1'b0, w_sub[0],
                           ~bus.opcode[4], bus.rn, bus.rd, w_ls_off};
            end
            default: w_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                      (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_active = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign w_mem_we = w_active && !w_empty;
    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_pop    = w_mem_we && bus.mem_ready;

`ifdef ILLEGAL_TRAP_EN
    localparam logic [31:0] c_TRAP_WORD = 32'hE100_0000;
    assign w_push      = w_accept;
    assign w_push_data = w_legal ? {bus.cond, w_body} : c_TRAP_WORD;
`else
    assign w_push      = w_accept && w_legal;
    assign w_push_data = {bus.cond, w_body};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + {{c_PTR_W{1'b0}}, 1'b1};
            if (w_pop)  r_rd_ptr <= r_rd_ptr + {{c_PTR_W{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr[c_PTR_W-1:0]] <= w_push_data;
    end

    // ------------------------------------------------------------------------
    // Session FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_sess_start = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt  = S_LOAD;
                    w_sess_start = 1'b1;
                end
            end
            S_LOAD:  if (bus.finish) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_empty && !w_mem_we) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_sess_start) begin
                r_addr  <= bus.base_addr;
                r_count <= '0;
                r_err   <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (r_count != c_COUNT_MAX) r_count <= r_count + {{ADDR_W{1'b0}}, 1'b1};
                end
                if (w_accept && !w_legal) r_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_LOAD) && !w_full;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = w_mem_we ? r_fifo[r_rd_ptr[c_PTR_W-1:0]] : 32'h0;
    assign bus.count     = r_count;
    assign bus.busy      = w_active;
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_iencoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_iencoder_loader
// Purpose  : Self-checking bench for iencoder_loader against a queue model.
// Revision : 1.0
// ============================================================================
module tb_iencoder_loader;
    localparam int ADDR_W     = 8;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [3:0]  cond;
        logic [6:0]  opcode;
        logic        s;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rm;
        logic [1:0]  sh;
        logic [4:0]  imm5;
        logic [11:0] imm12;
        logic [23:0] imm24;
    } beat_t;

    typedef enum int {M_IDLE, M_LOAD, M_DRAIN, M_DONE} mstate_e;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   rdy_pct  = 100;

    iencoder_loader_if #(.ADDR_W(ADDR_W)) bus();

    iencoder_loader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: assembles words arithmetically from ARM field positions.
    function automatic logic [32:0] ref_encode(input beat_t b);
        logic [3:0]  alu [6];
        int          grp;
        int          sub;
        logic [31:0] w;
        logic [31:0] c;
        logic        ok;
        logic [31:0] sreg;
        logic [31:0] rreg;
        logic [31:0] op4;
        logic [31:0] sb;
        logic [31:0] rn;
        alu  = '{4'h4, 4'h2, 4'hA, 4'h0, 4'hC, 4'h1};
        grp  = int'(b.opcode) / 8;
        sub  = int'(b.opcode) % 8;
        c    = 32'(b.cond) << 28;
        sreg = (32'(b.imm5) << 7) | (32'(b.sh) << 5) | 32'(b.rm);
        rreg = (32'(b.rs) << 8) | (32'(b.sh) << 5) | 32'h10 | 32'(b.rm);
        ok   = 1'b0;
        w    = 32'h0;
        op4  = 0; sb = 0; rn = 0;
        if ((grp == 1 || grp == 3 || grp == 7) && sub < 6) begin
            ok = 1'b1; op4 = 32'(alu[sub]); sb = (b.s || sub == 2) ? 1 : 0; rn = 32'(b.rn);
        end else if ((grp == 0 || grp == 2 || grp == 6) && sub == 0) begin
            ok = 1'b1; op4 = 13; sb = b.s ? 1 : 0; rn = 0;
        end
        if (ok) begin
            w = c | (op4 << 21) | (sb << 20) | (rn << 16) | (32'(b.rd) << 12);
            if (grp <= 1)      w = w | (1 << 25) | 32'(b.imm12);
            else if (grp <= 3) w = w | sreg;
            else               w = w | rreg;
        end else if (grp == 0 && sub == 1) begin
            ok = 1'b1; w = c | 32'h0100_0000;
        end else if (grp == 8 && (sub == 0 || sub == 4)) begin
            ok = 1'b1; w = c | (sub == 0 ? 32'h0A00_0000 : 32'h0B00_0000) | 32'(b.imm24);
        end else if (grp == 8 && (sub == 1 || sub == 5)) begin
            ok = 1'b1; w = c | (sub == 1 ? 32'h012F_FF10 : 32'h012F_FF30) | 32'(b.rm);
        end else if (grp == 8 || grp >= 12) begin
            int reg_f;
            int load;
            ok    = 1'b1;
            reg_f = (grp >= 12) ? grp % 2 : 0;
            load  = (grp == 8 || grp < 14) ? 1 : 0;
            rn    = (grp == 8) ? 15 : 32'(b.rn);
            w = c | (1 << 26) | (32'(reg_f) << 25) | (32'(sub / 4) << 24) |
                (32'((sub / 2) % 2) << 23) | (32'(sub % 2) << 21) | (32'(load) << 20) |
                (rn << 16) | (32'(b.rd) << 12) | (reg_f != 0 ? sreg : 32'(b.imm12));
        end
        return {ok, w};
    endfunction

    function automatic beat_t mk(input logic [6:0] op, input logic [3:0] rn, input logic [3:0] rd,
                                 input logic [3:0] rm, input logic [11:0] imm12, input logic [23:0] imm24);
        beat_t b;
        b = '0;
        b.cond = 4'hE; b.opcode = op; b.rn = rn; b.rd = rd; b.rm = rm;
        b.imm12 = imm12; b.imm24 = imm24;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t        b;
        logic [6:0]   specials [4];
        specials = '{7'b0000000, 7'b0000001, 7'b0010000, 7'b0110000};
        b.cond = 4'($urandom); b.s = 1'($urandom); b.rn = 4'($urandom); b.rd = 4'($urandom);
        b.rs = 4'($urandom); b.rm = 4'($urandom); b.sh = 2'($urandom); b.imm5 = 5'($urandom);
        b.imm12 = 12'($urandom); b.imm24 = 24'($urandom);
        case ($urandom_range(0, 7))
            0:       b.opcode = {4'b0001, 3'($urandom_range(0, 5))};
            1:       b.opcode = {4'b0011, 3'($urandom_range(0, 5))};
            2:       b.opcode = {4'b0111, 3'($urandom_range(0, 5))};
            3:       b.opcode = specials[$urandom_range(0, 3)];
            4:       b.opcode = {4'b1000, 3'($urandom)};
            5:       b.opcode = {2'b11, 5'($urandom)};
            default: b.opcode = 7'($urandom);
        endcase
        return b;
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural model: session state, pending-word queue, address, count
    // ------------------------------------------------------------------------
    mstate_e     m_st    = M_IDLE;
    logic [31:0] m_q[$];
    int          m_addr  = 0;
    int          m_count = 0;
    bit          m_err   = 1'b0;
    bit          m_can_in;
    bit          m_wr;
    int          m_pre;
    logic [32:0] m_enc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = M_IDLE; m_q.delete(); m_addr = 0; m_count = 0; m_err = 1'b0;
        end else begin
            m_pre    = m_q.size();
            m_can_in = (m_st == M_LOAD) && (m_pre < FIFO_DEPTH);
            m_wr     = (m_st == M_LOAD || m_st == M_DRAIN) && (m_pre > 0);
            if (m_wr && bus.mem_ready) begin
                void'(m_q.pop_front());
                m_addr = (m_addr + 1) % (1 << ADDR_W);
                if (m_count < (1 << (ADDR_W + 1)) - 1) m_count++;
            end
            if (m_can_in && bus.in_valid) begin
                m_enc = ref_encode({bus.cond, bus.opcode, bus.en_status, bus.rn, bus.rd, bus.rs,
                                    bus.rm, bus.shift_op, bus.imm5, bus.imm12, bus.imm24});
                if (m_enc[32]) m_q.push_back(m_enc[31:0]);
                else begin
                    m_err = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                    m_q.push_back(32'hE100_0000);
`endif
                end
            end
            case (m_st)
                M_IDLE, M_DONE: if (bus.start) begin
                    m_st = M_LOAD; m_addr = int'(bus.base_addr); m_count = 0; m_err = 1'b0;
                end
                M_LOAD:  if (bus.finish) m_st = M_DRAIN;
                default: if (m_pre == 0) m_st = M_DONE;
            endcase
        end
    end

    // Compare process and write log
    logic [ADDR_W+31:0] obs[$];
    bit                 e_we;

    always @(negedge clk) begin
        e_we = (m_st == M_LOAD || m_st == M_DRAIN) && m_q.size() > 0;
        chk("in_ready", 32'(bus.in_ready), 32'((m_st == M_LOAD) && m_q.size() < FIFO_DEPTH));
        chk("mem_we",   32'(bus.mem_we),   32'(e_we));
        chk("busy",     32'(bus.busy),     32'(m_st == M_LOAD || m_st == M_DRAIN));
        chk("done",     32'(bus.done),     32'(m_st == M_DONE));
        chk("err",      32'(bus.err),      32'(m_err));
        chk("count",    32'(bus.count),    32'(m_count));
        chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        if (e_we) chk("mem_wdata", bus.mem_wdata, m_q[0]);
        if (bus.mem_we && bus.mem_ready) obs.push_back({bus.mem_addr, bus.mem_wdata});
    end

    initial begin
        bus.mem_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.mem_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        bus.start = 1'b1; bus.base_addr = base;
        cyc(1);
        bus.start = 1'b0;
    endtask

    task automatic do_finish();
        bus.finish = 1'b1;
        cyc(1);
        bus.finish = 1'b0;
    endtask

    task automatic send(input beat_t b, input bit with_finish);
        int budget;
        bit got;
        bus.cond = b.cond; bus.opcode = b.opcode; bus.en_status = b.s; bus.rn = b.rn;
        bus.rd = b.rd; bus.rs = b.rs; bus.rm = b.rm; bus.shift_op = b.sh;
        bus.imm5 = b.imm5; bus.imm12 = b.imm12; bus.imm24 = b.imm24;
        bus.in_valid = 1'b1;
        got = 1'b0; budget = 0;
        while (!got && budget < 300) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                if (with_finish) bus.finish = 1'b1;
            end
            @(posedge clk); #1;
            budget++;
        end
        if (!got) chk("accept_timeout", 32'(got), 32'd1);
        bus.in_valid = 1'b0; bus.finish = 1'b0;
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while (!bus.done && budget < 500) begin cyc(1); budget++; end
        chk("done_timeout", 32'(bus.done), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int    nb;
        bit    fin;
        bus.start = 0; bus.base_addr = '0; bus.finish = 0; bus.in_valid = 0;
        bus.cond = 0; bus.opcode = 0; bus.en_status = 0; bus.rn = 0; bus.rd = 0;
        bus.rs = 0; bus.rm = 0; bus.shift_op = 0; bus.imm5 = 0; bus.imm12 = 0; bus.imm24 = 0;

        // Pin the reference encoder to hand-assembled words
        chk("model_add",  ref_encode(mk(7'b0001000, 4'd1, 4'd2, 4'd0, 12'h005, 24'h0))[31:0], 32'hE281_2005);
        chk("model_b",    ref_encode(mk(7'b1000000, 4'd0, 4'd0, 4'd0, 12'h0, 24'h000010))[31:0], 32'hEA00_0010);
        chk("model_bx",   ref_encode(mk(7'b1000001, 4'd0, 4'd0, 4'd14, 12'h0, 24'h0))[31:0], 32'hE12F_FF1E);
        chk("model_ldr",  ref_encode(mk(7'b1100110, 4'd1, 4'd0, 4'd0, 12'h004, 24'h0))[31:0], 32'hE591_0004);
        chk("model_cmp",  ref_encode(mk(7'b0001010, 4'd3, 4'd0, 4'd0, 12'h000, 24'h0))[31:0], 32'hE353_0000);
        chk("model_halt", ref_encode(mk(7'b0000001, 4'd5, 4'd5, 4'd5, 12'hFFF, 24'h0))[31:0], 32'hE100_0000);
        chk("model_ill",  32'(ref_encode(mk(7'b0000111, 4'd0, 4'd0, 4'd0, 12'h0, 24'h0))[32]), 32'd0);

        #1 rst_n = 1'b0;
        #1;
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        // Single ADD immediate
        obs.delete();
        do_start(8'h10);
        send(mk(7'b0001000, 4'd1, 4'd2, 4'd0, 12'h005, 24'h0), 1'b1);
        wait_done();
        chk("add_word", obs[0][31:0], 32'hE281_2005);
        chk("add_addr", 32'(obs[0][ADDR_W+31:32]), 32'h10);
        chk("add_count", 32'(bus.count), 32'd1);

        // Branch, branch-exchange, load, compare in consecutive addresses
        obs.delete();
        do_start(8'h20);
        send(mk(7'b1000000, 4'd0, 4'd0, 4'd0, 12'h0, 24'h000010), 1'b0);
        send(mk(7'b1000001, 4'd0, 4'd0, 4'd14, 12'h0, 24'h0), 1'b0);
        send(mk(7'b1100110, 4'd1, 4'd0, 4'd0, 12'h004, 24'h0), 1'b0);
        send(mk(7'b0001010, 4'd3, 4'd0, 4'd0, 12'h000, 24'h0), 1'b0);
        do_finish();
        wait_done();
        chk("seq_w0", obs[0], {8'h20, 32'hEA00_0010});
        chk("seq_w1", obs[1], {8'h21, 32'hE12F_FF1E});
        chk("seq_w2", obs[2], {8'h22, 32'hE591_0004});
        chk("seq_w3", obs[3], {8'h23, 32'hE353_0000});

        // Stalled memory, FIFO fill and address wrap
        obs.delete();
        rdy_pct = 0;
        cyc(1);
        do_start(8'hFE);
        for (int i = 0; i < FIFO_DEPTH; i++)
            send(mk(7'b0001000, 4'd1, 4'(i), 4'd0, 12'(i + 1), 24'h0), 1'b0);
        @(negedge clk);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        cyc(3);
        rdy_pct = 100;
        do_finish();
        wait_done();
        chk("wrap_a0", 32'(obs[0][ADDR_W+31:32]), 32'hFE);
        chk("wrap_a2", 32'(obs[2][ADDR_W+31:32]), 32'h00);
        chk("wrap_count", 32'(bus.count), 32'(FIFO_DEPTH));

        // Illegal opcode
        obs.delete();
        do_start(8'h40);
        send(mk(7'b0000111, 4'd0, 4'd0, 4'd0, 12'h0, 24'h0), 1'b1);
        wait_done();
        chk("ill_err", 32'(bus.err), 32'd1);
`ifdef ILLEGAL_TRAP_EN
        chk("ill_count", 32'(bus.count), 32'd1);
        chk("ill_word", obs[0][31:0], 32'hE100_0000);
`else
        chk("ill_count", 32'(bus.count), 32'd0);
`endif

        // Reset with words pending
        rdy_pct = 0;
        cyc(1);
        do_start(8'h80);
        send(mk(7'b0001000, 4'd1, 4'd2, 4'd0, 12'h1, 24'h0), 1'b0);
        send(mk(7'b0001001, 4'd1, 4'd2, 4'd0, 12'h2, 24'h0), 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
        chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        rdy_pct = 100;
        cyc(5);
        chk("post_rst_we", 32'(bus.mem_we), 32'd0);

        // Randomized sessions
        for (int s = 0; s < 40; s++) begin
            rdy_pct = $urandom_range(20, 100);
            if ($urandom_range(0, 3) == 0) do_finish();
            do_start(8'($urandom));
            nb  = $urandom_range(1, 10);
            fin = 1'b0;
            for (int k = 0; k < nb; k++) begin
                cyc($urandom_range(0, 2));
                if ($urandom_range(0, 7) == 0) begin
                    bus.start = 1'b1; bus.base_addr = 8'($urandom);
                end
                fin = (k == nb - 1) && ($urandom_range(0, 1) == 1);
                send(rand_beat(), fin);
                bus.start = 1'b0;
            end
            if (!fin) do_finish();
            wait_done();
            cyc($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
